// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one multi-cycle memory port between IF and MEM stages,
//            data first with a bounded fetch-starvation limit.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_LIM = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_ack_o,
   input  logic              dm_req_i,
   input  logic              dm_we_i,
   input  logic [ADDR_W-1:0] dm_addr_i,
   input  logic [DATA_W-1:0] dm_wdata_i,
   output logic [DATA_W-1:0] dm_rdata_o,
   output logic              dm_ack_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_ack_i,
   output logic              stall_o
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_BUSY_IF = 3'd1,
      S_BUSY_DM = 3'd2,
      S_RESP_IF = 3'd3,
      S_RESP_DM = 3'd4
   } state_t;

   localparam logic [3:0] c_starve_lim = 4'(STARVE_LIM);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [3:0]        r_streak;
   logic              w_grant_dm;
   logic              w_grant_if;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [DATA_W-1:0] r_if_rdata;
   logic [DATA_W-1:0] r_dm_rdata;

   always_comb begin
      w_state_nxt = r_state;
      w_grant_dm  = 1'b0;
      w_grant_if  = 1'b0;
      case (r_state)
         S_IDLE: begin
            // Data wins unless fetch has already waited out its allowance
            if (dm_req_i && !(if_req_i && (r_streak == c_starve_lim))) begin
               w_grant_dm  = 1'b1;
               w_state_nxt = S_BUSY_DM;
            end else if (if_req_i) begin
               w_grant_if  = 1'b1;
               w_state_nxt = S_BUSY_IF;
            end
         end
         S_BUSY_IF: if (mem_ack_i) w_state_nxt = S_RESP_IF;
         S_BUSY_DM: if (mem_ack_i) w_state_nxt = S_RESP_DM;
         S_RESP_IF: w_state_nxt = S_IDLE;
         S_RESP_DM: w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= S_IDLE;
         r_streak    <= 4'd0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_if_rdata  <= '0;
         r_dm_rdata  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_grant_dm) begin
            r_mem_we    <= dm_we_i;
            r_mem_addr  <= dm_addr_i;
            r_mem_wdata <= dm_wdata_i;
            if (!if_req_i)
               r_streak <= 4'd0;
            else if (r_streak < c_starve_lim)
               r_streak <= r_streak + 4'd1;
         end
         if (w_grant_if) begin
            r_mem_we   <= 1'b0;
            r_mem_addr <= if_addr_i;
            r_streak   <= 4'd0;
         end
         if ((r_state == S_BUSY_IF) && mem_ack_i)
            r_if_rdata <= mem_rdata_i;
         // Writes leave the last read value visible to the MEM stage
         if ((r_state == S_BUSY_DM) && mem_ack_i && !r_mem_we)
            r_dm_rdata <= mem_rdata_i;
      end
   end

   assign mem_req_o   = (r_state == S_BUSY_IF) || (r_state == S_BUSY_DM);
   assign mem_we_o    = r_mem_we;
   assign mem_addr_o  = r_mem_addr;
   assign mem_wdata_o = r_mem_wdata;
   assign if_ack_o    = (r_state == S_RESP_IF);
   assign dm_ack_o    = (r_state == S_RESP_DM);
   assign if_rdata_o  = r_if_rdata;
   assign dm_rdata_o  = r_dm_rdata;
   assign stall_o     = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported, multi-cycle memory between the instruction-fetch stage and the data-memory stage of the 5-stage pipeline. Each side gets a request/acknowledge interface. The block serialises accesses, gives data accesses priority with a bounded-starvation guarantee for fetch, and produces a pipeline stall while either side waits. It sits between the stage logic (PC/IF and MEM) and the shared memory model.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIM, 4, consecutive data grants allowed while fetch waits (range 1..15)

- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous, active-high reset
- if_req_i  in  1  fetch request, held until if_ack_o
- if_addr_i  in  ADDR_W  fetch address
- if_rdata_o  out  DATA_W  fetched word, registered
- if_ack_o  out  1  one-cycle completion pulse
- dm_req_i  in  1  data request, held until dm_ack_o
- dm_we_i  in  1  1 = write, 0 = read
- dm_addr_i  in  ADDR_W  data address
- dm_wdata_i  in  DATA_W  write data
- dm_rdata_o  out  DATA_W  read data, registered
- dm_ack_o  out  1  one-cycle completion pulse
- mem_req_o  out  1  memory request, held until mem_ack_i
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address, registered
- mem_wdata_o  out  DATA_W  memory write data, registered
- mem_rdata_i  in  DATA_W  memory read data, valid with mem_ack_i
- mem_ack_i  in  1  memory completion, may arrive 1..N cycles after mem_req_o rises
- stall_o  out  1  pipeline stall

## Operation
- Clock and reset: one clock `clk_i`. Reset `rst_i` is synchronous and active-high.
- FSM states:
  - IDLE, BUSY_IF, BUSY_DM, RESP_IF, RESP_DM.
- IDLE grant decision:
  - If `dm_req_i` is high and not (`if_req_i` && streak == STARVE_LIM): go to BUSY_DM.
  - Else if `if_req_i` is high: go to BUSY_IF.
  - Else stay in IDLE.
- On a grant:
  - Latch address, and for data also `we` and `wdata`, into the `mem_*_o` registers.
  - Latching fetch forces `mem_we_o` = 0.
- BUSY_x:
  - `mem_req_o` = 1 and registered outputs are held stable.
  - On `mem_ack_i` = 1, capture `mem_rdata_i` into `x_rdata_o`, then go to RESP_x.
  - On a data write, `dm_rdata_o` is not updated.
- RESP_x:
  - `x_ack_o` = 1 for exactly this cycle, `mem_req_o` = 0, no grant is made.
  - Next state is IDLE. This prevents re-granting a request that the requester drops on ack.
- Starvation counter `streak` (4 bits):
  - On a DM grant with `if_req_i` high: increment.
  - On a DM grant with `if_req_i` low: clear to 0.
  - On an IF grant: clear to 0.
  - Saturates at STARVE_LIM.
- `stall_o` = (`if_req_i` & ~`if_ack_o`) | (`dm_req_i` & ~`dm_ack_o`). Combinational.
- `mem_ack_i` is ignored in IDLE and RESP_x.
- Request inputs must stay stable while req is high. Changing them mid-transaction has no effect, because the values were already latched.

## Timing
- Reset values:
  - state = IDLE
  - `mem_req_o` = 0, `mem_we_o` = 0, `mem_addr_o` = 0, `mem_wdata_o` = 0
  - `if_rdata_o` = 0, `dm_rdata_o` = 0
  - `if_ack_o` = 0, `dm_ack_o` = 0
  - `streak` = 0
- Reset mid-transaction: the outstanding memory access is abandoned. `mem_req_o` drops the cycle after reset is sampled, and no ack is ever issued for that access.
- Request latency:
  - A request seen in IDLE at edge N gives `mem_req_o` = 1 from cycle N+1.
  - `mem_ack_i` sampled at edge M gives `x_ack_o` = 1 in cycle M+1.
  - IDLE follows at M+2.
- Minimum turnaround with a 1-cycle memory: 3 cycles from req to next grant opportunity.
- Simultaneous `if_req_i` and `dm_req_i` in IDLE: DM wins unless `streak` == STARVE_LIM.
- The two ack outputs are never high in the same cycle.

## Test plan
- Single fetch, memory acks after 2 cycles, `mem_rdata_i` = 0x00500093:
  - `mem_req_o` high for 2 cycles, `mem_we_o` = 0.
  - `if_ack_o` pulses once, `if_rdata_o` = 0x00500093.
  - `stall_o` high from request until the ack cycle.
- Data write, addr 0x40, wdata 0xDEADBEEF, 1-cycle memory:
  - `mem_we_o` = 1, `mem_addr_o` = 0x40, `mem_wdata_o` = 0xDEADBEEF.
  - `dm_ack_o` pulses once, `dm_rdata_o` stays 0.
- IF and DM requested in the same cycle: DM granted first (read 0x80 returns 0x12). IF is granted after RESP_DM, and no ack overlaps.
- `if_req_i` held high and `dm_req_i` re-asserted immediately after each ack, STARVE_LIM = 4: exactly 4 DM grants occur, then 1 IF grant, then DM resumes.
- `rst_i` asserted during BUSY_DM with `mem_ack_i` still low: next cycle state = IDLE, `mem_req_o` = 0, no `dm_ack_o`, and a late `mem_ack_i` is ignored.
- No requests for 10 cycles with `mem_ack_i` toggling randomly: `mem_req_o`, both acks and `stall_o` stay 0.
